// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
// Pop-side controller for the single-port line FIFO feeding the convolution
// window loader. A start command pops burst_len words. The writer gets the
// FIFO port whenever it raises push_req. Popped words reach a valid/ready
// stream through a 2-entry output buffer.
//
// Ports:
//   clk, reset (async, active-low)
//   start, burst_len       burst command, sampled only in IDLE
//   push_req               writer owns the FIFO port this cycle (priority)
//   fifo_en, fifo_push_pop FIFO port controls (push_pop always 0 = pop)
//   fifo_data, fifo_empty  FIFO read data (valid in pop cycle) and empty flag
//   out_valid/out_ready/out_data  output stream, head of 2-entry buffer
//   busy                   state != IDLE
//   done                   one-cycle pulse in the DONE state
//   stall_cnt              FETCH cycles spent waiting on an empty FIFO
//
// Optional feature: define FIFO_RD_STALL_CNT_EN to build the stall counter.
// When it is undefined, stall_cnt is tied to zero.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  burst_len,
  input  logic                  push_req,
  output logic                  fifo_en,
  output logic                  fifo_push_pop,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           stall_cnt
);

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH, DONE} state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;  // head entry
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic                  pop;
  logic                  consume;
  logic                  start_acc;

  // out_ready reaches the pop decision only through the registered occupancy.
  always_comb begin
    pop     = (state_q == FETCH) && (remaining_q != '0) && !fifo_empty &&
              !push_req && (occ_q != 2'd2);
    consume = (occ_q != 2'd0) && out_ready;
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    start_acc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          start_acc   = 1'b1;
          remaining_d = burst_len;
          state_d     = (burst_len != '0) ? FETCH : DONE;
        end
      end
      FETCH: begin
        if (pop) remaining_d = remaining_q - 1'b1;
        // Leave at the same edge as the final pop.
        if (remaining_d == '0) state_d = FLUSH;
      end
      FLUSH: begin
        if (occ_q == 2'd0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift-style buffer: the head always lives in buf0.
  // Pop and consume together only happen at occ=1, so the new word becomes the head.
  always_comb begin
    occ_d  = occ_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    unique case ({pop, consume})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = fifo_data;
        else               buf1_d = fifo_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        buf0_d = fifo_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      occ_q       <= '0;
      buf0_q      <= '0;
      buf1_q      <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      occ_q       <= occ_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
    end
  end

`ifdef FIFO_RD_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_acc)
      stall_d = '0;
    else if ((state_q == FETCH) && (remaining_q != '0) && fifo_empty && (stall_q != '1))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

  assign fifo_en       = pop;
  assign fifo_push_pop = 1'b0;
  assign out_valid     = (occ_q != 2'd0);
  assign out_data      = buf0_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Testbench for fifo_burst_reader. The FIFO is a queue inside the bench. A
// transaction-level model tracks the burst phase, the remaining word count and
// a queue of buffered words. Each scenario task compares the DUT against that
// model on every cycle.
module tb_fifo_burst_reader;

  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_FLUSH = 2;
  localparam int M_DONE  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  burst_len = '0;
  logic        push_req = 1'b0;
  logic        fifo_en, fifo_push_pop;
  logic [7:0]  fifo_data = '0;
  logic        fifo_empty = 1'b1;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        busy, done;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_burst_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .burst_len(burst_len),
    .push_req(push_req), .fifo_en(fifo_en), .fifo_push_pop(fifo_push_pop),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done),
    .stall_cnt(stall_cnt)
  );

  logic [7:0]  fifo_q[$];
  logic [7:0]  m_buf[$];
  int          m_mode = M_IDLE;
  int          m_rem = 0;
  int          m_stall = 0;

  logic [7:0]  dut_words[$];
  int          n_pop, n_done;
  logic [4:0]  exp_ctl, obs_ctl;
  logic        exp_valid;
  logic [7:0]  exp_data, obs_data;
  logic [15:0] exp_stall, obs_stall;

  // One clock cycle: drive inputs, predict outputs, sample the DUT at the
  // falling edge, then advance the FIFO and the model across the rising edge.
  task automatic cycle(input logic st, input int len, input logic preq,
                       input logic rdy, input logic wpush, input logic [7:0] wword);
    logic pop, cons, was_empty;
    start      = st;
    burst_len  = len[3:0];
    push_req   = preq;
    out_ready  = rdy;
    was_empty  = (fifo_q.size() == 0);
    fifo_empty = was_empty;
    fifo_data  = was_empty ? 8'h00 : fifo_q[0];

    pop  = (m_mode == M_FETCH) && (m_rem > 0) && !was_empty && !preq && (m_buf.size() < 2);
    cons = (m_buf.size() > 0) && rdy;
    exp_valid = (m_buf.size() > 0);
    exp_data  = exp_valid ? m_buf[0] : 8'h00;
    exp_ctl   = {pop, 1'b0, exp_valid, m_mode == M_DONE, m_mode != M_IDLE};
`ifdef FIFO_RD_STALL_CNT_EN
    exp_stall = m_stall[15:0];
`else
    exp_stall = 16'h0000;
`endif

    @(negedge clk);
    obs_ctl   = {fifo_en, fifo_push_pop, out_valid, done, busy};
    obs_data  = out_data;
    obs_stall = stall_cnt;
    if (out_valid && rdy) dut_words.push_back(out_data);
    if (fifo_en) n_pop++;
    if (done) n_done++;

    case (m_mode)
      M_IDLE: if (st) begin
        m_rem   = len & 15;
        m_stall = 0;
        m_mode  = (m_rem != 0) ? M_FETCH : M_DONE;
      end
      M_FETCH: begin
        if (m_rem > 0 && was_empty && m_stall < 65535) m_stall++;
        if (pop) m_rem--;
        if (m_rem == 0) m_mode = M_FLUSH;
      end
      M_FLUSH: if (m_buf.size() == 0) m_mode = M_DONE;
      default: m_mode = M_IDLE;
    endcase
    if (cons) void'(m_buf.pop_front());
    if (pop) m_buf.push_back(fifo_q.pop_front());
    if (wpush) fifo_q.push_back(wword);

    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    dut_words.delete();
    n_pop  = 0;
    n_done = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({fifo_en, fifo_push_pop, out_valid, out_data, busy, done, stall_cnt} !== 29'd0) begin
      errors++;
      $display("FAIL reset outputs got en%b pp%b v%b d%h b%b dn%b st%h want all 0",
               fifo_en, fifo_push_pop, out_valid, out_data, busy, done, stall_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [7:0] want[$];
    bit fin = 0;
    want = '{8'h11, 8'h22, 8'h33};
    fifo_q = '{8'h11, 8'h22, 8'h33};
    clear_obs();
    for (int i = 0; i < 30; i++) begin
      cycle(i == 0, 3, 1'b0, 1'b1, 1'b0, 8'h00);
      checks++;
      if (obs_ctl !== exp_ctl || obs_stall !== exp_stall || (exp_valid && obs_data !== exp_data)) begin
        errors++;
        $display("FAIL basic cyc%0d ctl %b want %b data %h want %h stall %0d want %0d",
                 i, obs_ctl, exp_ctl, obs_data, exp_data, obs_stall, exp_stall);
      end
      if (i > 0 && m_mode == M_IDLE) begin fin = 1; break; end
    end
    checks++;
    if (!fin || n_pop != 3 || n_done != 1 || dut_words.size() != 3) begin
      errors++;
      $display("FAIL basic_totals fin %0d pops %0d want 3 dones %0d want 1 words %0d want 3",
               fin, n_pop, n_done, dut_words.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (dut_words[k] !== want[k]) begin
          errors++;
          $display("FAIL basic_word%0d got %h want %h", k, dut_words[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] want[$];
    bit fin = 0;
    for (int k = 0; k < 4; k++) want.push_back(8'($urandom));
    fifo_q = want;
    clear_obs();
    for (int i = 0; i < 40; i++) begin
      // start held high during the stall must be ignored
      cycle(i < 6, (i == 0) ? 4 : 9, 1'b0, i >= 6, 1'b0, 8'h00);
      checks++;
      if (obs_ctl !== exp_ctl || obs_stall !== exp_stall || (exp_valid && obs_data !== exp_data)) begin
        errors++;
        $display("FAIL backpressure cyc%0d ctl %b want %b data %h want %h stall %0d want %0d",
                 i, obs_ctl, exp_ctl, obs_data, exp_data, obs_stall, exp_stall);
      end
      if (i == 5) begin
        checks++;
        if (n_pop != 2) begin
          errors++;
          $display("FAIL backpressure_held_pops got %0d want 2", n_pop);
        end
      end
      if (i > 0 && m_mode == M_IDLE) begin fin = 1; break; end
    end
    checks++;
    if (!fin || dut_words.size() != 4 || n_done != 1) begin
      errors++;
      $display("FAIL backpressure_totals fin %0d words %0d want 4 dones %0d want 1",
               fin, dut_words.size(), n_done);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (dut_words[k] !== want[k]) begin
          errors++;
          $display("FAIL backpressure_word%0d got %h want %h", k, dut_words[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_push_req();
    logic [7:0] want[$];
    bit fin = 0;
    for (int k = 0; k < 6; k++) want.push_back(8'($urandom));
    fifo_q = want;
    clear_obs();
    for (int i = 0; i < 40; i++) begin
      cycle(i == 0, 4, (i == 2 || i == 3), 1'b1, (i == 2 || i == 3), 8'($urandom));
      checks++;
      if (obs_ctl !== exp_ctl || obs_stall !== exp_stall || (exp_valid && obs_data !== exp_data)) begin
        errors++;
        $display("FAIL push_req cyc%0d ctl %b want %b data %h want %h stall %0d want %0d",
                 i, obs_ctl, exp_ctl, obs_data, exp_data, obs_stall, exp_stall);
      end
      if (i > 0 && m_mode == M_IDLE) begin fin = 1; break; end
    end
    checks++;
    if (!fin || n_pop != 4 || dut_words.size() != 4) begin
      errors++;
      $display("FAIL push_req_totals fin %0d pops %0d want 4 words %0d want 4",
               fin, n_pop, dut_words.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (dut_words[k] !== want[k]) begin
          errors++;
          $display("FAIL push_req_word%0d got %h want %h", k, dut_words[k], want[k]);
        end
      end
    end
    fifo_q.delete();
  endtask

  task automatic test_empty_stall();
    bit fin = 0;
    logic [15:0] want_stall;
`ifdef FIFO_RD_STALL_CNT_EN
    want_stall = 16'd6;
`else
    want_stall = 16'd0;
`endif
    fifo_q.delete();
    clear_obs();
    for (int i = 0; i < 40; i++) begin
      cycle(i == 0, 2, (i == 7 || i == 8), 1'b1, (i == 7 || i == 8),
            (i == 7) ? 8'hA1 : 8'hA2);
      checks++;
      if (obs_ctl !== exp_ctl || obs_stall !== exp_stall || (exp_valid && obs_data !== exp_data)) begin
        errors++;
        $display("FAIL empty_stall cyc%0d ctl %b want %b data %h want %h stall %0d want %0d",
                 i, obs_ctl, exp_ctl, obs_data, exp_data, obs_stall, exp_stall);
      end
      if (i == 7) begin
        checks++;
        if (obs_stall !== want_stall || n_pop != 0) begin
          errors++;
          $display("FAIL empty_stall_count stall %0d want %0d pops %0d want 0",
                   obs_stall, want_stall, n_pop);
        end
      end
      if (i > 0 && m_mode == M_IDLE) begin fin = 1; break; end
    end
    checks++;
    if (!fin || dut_words.size() != 2 || dut_words[0] !== 8'hA1 || dut_words[1] !== 8'hA2) begin
      errors++;
      $display("FAIL empty_stall_words fin %0d count %0d want 2 (A1,A2)", fin, dut_words.size());
    end
  endtask

  task automatic test_zero_len();
    fifo_q = '{8'h5A, 8'h6B, 8'h7C};
    clear_obs();
    for (int i = 0; i < 5; i++) begin
      // second start arrives while busy in DONE and must be dropped
      cycle(i <= 1, (i == 0) ? 0 : 3, 1'b0, 1'b1, 1'b0, 8'h00);
      checks++;
      if (obs_ctl !== exp_ctl || obs_stall !== exp_stall || (exp_valid && obs_data !== exp_data)) begin
        errors++;
        $display("FAIL zero_len cyc%0d ctl %b want %b data %h want %h stall %0d want %0d",
                 i, obs_ctl, exp_ctl, obs_data, exp_data, obs_stall, exp_stall);
      end
      if (i == 1) begin
        checks++;
        if (obs_ctl[1:0] !== 2'b11) begin
          errors++;
          $display("FAIL zero_len_done done/busy %b want 11", obs_ctl[1:0]);
        end
      end
    end
    checks++;
    if (n_pop != 0 || n_done != 1) begin
      errors++;
      $display("FAIL zero_len_totals pops %0d want 0 dones %0d want 1", n_pop, n_done);
    end
    fifo_q.delete();
  endtask

  task automatic test_abort();
    for (int k = 0; k < 4; k++) fifo_q.push_back(8'($urandom));
    clear_obs();
    for (int i = 0; i < 3; i++) begin
      cycle(i == 0, 4, 1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if (obs_ctl !== exp_ctl || (exp_valid && obs_data !== exp_data)) begin
        errors++;
        $display("FAIL abort_setup cyc%0d ctl %b want %b data %h want %h",
                 i, obs_ctl, exp_ctl, obs_data, exp_data);
      end
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({fifo_en, out_valid, out_data, busy, done, stall_cnt} !== 28'd0) begin
      errors++;
      $display("FAIL abort_async got en%b v%b d%h b%b dn%b st%h want all 0",
               fifo_en, out_valid, out_data, busy, done, stall_cnt);
    end
    m_buf.delete();
    m_mode  = M_IDLE;
    m_rem   = 0;
    m_stall = 0;
    fifo_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    for (int b = 0; b < 10; b++) begin
      int len;
      bit fin;
      logic preq;
      fin = 0;
      len = $urandom_range(0, 9);
      repeat ($urandom_range(0, 4)) fifo_q.push_back(8'($urandom));
      for (int i = 0; i < 300; i++) begin
        preq = ($urandom_range(0, 3) == 0) || (fifo_q.size() == 0 && $urandom_range(0, 1) == 1);
        cycle(i == 0, len, preq, $urandom_range(0, 3) != 0,
              preq && fifo_q.size() < 14, 8'($urandom));
        checks++;
        if (obs_ctl !== exp_ctl || obs_stall !== exp_stall || (exp_valid && obs_data !== exp_data)) begin
          errors++;
          $display("FAIL random b%0d cyc%0d ctl %b want %b data %h want %h stall %0d want %0d",
                   b, i, obs_ctl, exp_ctl, obs_data, exp_data, obs_stall, exp_stall);
        end
        if (i > 0 && m_mode == M_IDLE) begin fin = 1; break; end
      end
      if (!fin) begin
        checks++;
        errors++;
        $display("FAIL random_timeout b%0d burst did not complete, mode %0d want idle", b, m_mode);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_backpressure();
    test_push_req();
    test_empty_stall();
    test_zero_len();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Pop-side controller for the single-port convolution FIFO (shared `en`/`push_pop` port, `full_signal`/`empty_signal` flags). On a `start` command it pops a programmed number of words, yields the FIFO port to the writer whenever the writer requests it, and presents the words to the convolution datapath on a valid/ready stream through a 2-entry output buffer. It sits between the line FIFO and the convolution window loader.

## Interface
- `DATA_WIDTH`, default 8: FIFO and stream word width.
- `CNT_WIDTH`, default 4: burst length counter width.
- `clk` in 1: sole clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: begin burst; sampled only in IDLE.
- `burst_len` in CNT_WIDTH: words to pop; sampled with `start`.
- `push_req` in 1: writer wants the FIFO port this cycle; it has priority.
- `fifo_en` out 1: FIFO enable (to FIFO `en`).
- `fifo_push_pop` out 1: FIFO direction (1=push, 0=pop). This block always drives 0.
- `fifo_data` in DATA_WIDTH: FIFO `DATA_OUT`, valid combinationally in the pop cycle.
- `fifo_empty` in 1: FIFO `empty_signal`.
- `out_valid` out 1, `out_ready` in 1, `out_data` out DATA_WIDTH: output stream.
- `busy` out 1: high outside IDLE.
- `done` out 1: one-cycle pulse at burst completion.
- `stall_cnt` out 16: empty-stall cycle counter (see Configuration).

## Operation
- FSM states:
  - IDLE: `start`=1 loads `remaining`=`burst_len`. Goes to FETCH if `burst_len`≠0, else DONE.
  - FETCH: pops until `remaining`=0, then goes to FLUSH.
  - FLUSH: waits for output buffer occupancy 0, then goes to DONE.
  - DONE: `done`=1 for one cycle, then returns to IDLE.
- Pop issue (combinational), pop = state==FETCH && `remaining`≠0 && !`fifo_empty` && !`push_req` && occ<2.
- On pop: `fifo_en`=1, `fifo_push_pop`=0. `fifo_data` is written into the buffer tail at the same edge, and `remaining` decrements.
- When not popping: `fifo_en`=0. The writer drives the FIFO port through its own mux when `push_req`=1. This block never asserts `fifo_en` in a cycle where `push_req`=1.
- `out_ready` does not combinationally affect `fifo_en`. The only path is the registered occupancy.
- Output buffer:
  - 2 entries, FIFO-ordered, occupancy `occ` 0..2. `out_valid`=(occ≠0), `out_data`=head.
  - Pop and consume in the same cycle: occ unchanged, data order preserved.
- `start` outside IDLE is ignored. `burst_len` is not re-sampled mid-burst.
- `busy` = state≠IDLE. This includes DONE.

## Timing
- Reset values:
  - state=IDLE, occ=0, `remaining`=0, `stall_cnt`=0.
  - `fifo_en`=0, `fifo_push_pop`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0.
- Reset asserted mid-burst aborts immediately. Buffered words are discarded and all outputs return to their reset values. FIFO pointers are not touched by this block.
- Latency, `start` to first pop: `start` at edge N → FETCH from N+1. The first pop occurs in cycle N+1 if FIFO non-empty and `push_req`=0. The word appears at `out_valid` in cycle N+2.
- Throughput: 1 word/cycle sustained while the FIFO is non-empty, `push_req`=0 and `out_ready`=1. Occupancy holds at 1.
- With `out_ready`=0: at most 2 pops, then stall at occ=2 until a consume.
- Completion: `done` asserts the cycle after the last buffered word is consumed plus one (FLUSH→DONE edge). IDLE follows on the next edge.
- `burst_len`=0: IDLE→DONE→IDLE. `done` appears 1 cycle after `start` and no pops are issued.
- FIFO wrap-around is transparent; the block relies only on `fifo_empty`.

## Configuration
- `FIFO_RD_STALL_CNT_EN` defined:
  - `stall_cnt` increments each FETCH cycle with `remaining`≠0 and `fifo_empty`=1.
  - It saturates at 16'hFFFF and clears on `start` acceptance.
- Undefined: counter logic is not compiled and `stall_cnt` is tied to 0.

## Test plan
- FIFO preloaded with 0x11,0x22,0x33. `start` with `burst_len`=3 and `out_ready`=1 → pops on 3 consecutive cycles, `out_data` 0x11,0x22,0x33 on consecutive cycles, one `done` pulse, `busy` low after.
- `burst_len`=4 with `out_ready`=0 for 5 cycles → exactly 2 pops, occ=2, `fifo_en`=0 while held. Releasing `out_ready` delivers all 4 words in order.
- `push_req`=1 for 2 cycles mid-burst → `fifo_en`=0 in those cycles, no data lost or duplicated, popping resumes the cycle `push_req` drops.
- FIFO empty at `start` with `burst_len`=2 and 6 cycles of empty → no pops. With the macro defined, `stall_cnt`=6, then the burst completes after words are pushed.
- `start` with `burst_len`=0 → `done` 1 cycle later and `fifo_en` never asserted. A second `start` while `busy` is ignored.
- Reset low mid-burst with occ=2 → `out_valid`=0, state IDLE, `fifo_en`=0 immediately (asynchronous).
